eth_send: RTL and testbench

- Ethernet transmit framer; the egress counterpart of the eth_recv receiver.
- On a start pulse it serialises one complete frame, one byte per clock, toward the PHY byte interface. The frame is either an ARP request/reply or an IPv4/UDP datagram.
- It generates the preamble/SFD, MAC header, ARP body or IPv4+UDP headers (IP checksum computed), pulls the UDP payload from an external FWFT buffer, pads to minimum length, and appends the FCS.

---
 rtl/eth_pkg.sv | 59 +++++
 rtl/eth_send_if.sv | 13 +
 rtl/eth_crc32_tx.sv | 36 +++
 rtl/eth_send.sv | 228 ++++++++++++++++++++++
 tb/tb_eth_send.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit framer.
// Holds the packet-type encoding (shared with the receiver), framing constants, the
// transmit FSM state type and the IPv4 header checksum / CRC-32 byte-update helpers.
package eth_pkg;

    typedef enum logic [1:0] {
        PktNone    = 2'd0,
        PktArpReq  = 2'd1,
        PktArpResp = 2'd2,
        PktUdp     = 2'd3
    } pkt_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StPreamble,
        StHeader,
        StPayload,
        StPad,
        StFcs,
        StIfg
    } tx_state_e;

    localparam logic [15:0] EtypeArp     = 16'h0806;
    localparam logic [15:0] EtypeIpv4    = 16'h0800;
    // HTYPE=1 (Ethernet), PTYPE=IPv4, HLEN=6, PLEN=4
    localparam logic [47:0] ArpFixedHdr  = 48'h0001_0800_0604;
    localparam logic [7:0]  PreambleByte = 8'h55;
    localparam logic [7:0]  SfdByte      = 8'hD5;
    // Byte counts measured from the first byte after the SFD
    localparam logic [10:0] HdrLen       = 11'd42;
    localparam logic [10:0] MinFrameLen  = 11'd60;
    localparam logic [31:0] CrcPolyRefl  = 32'hEDB8_8320;

    // One's-complement checksum of the ten IPv4 header words (checksum field as zero).
    function automatic logic [15:0] ip_csum(input logic [15:0] total_len,
                                            input logic [15:0] id,
                                            input logic [7:0]  ttl,
                                            input logic [31:0] src,
                                            input logic [31:0] dst);
        logic [19:0] acc;
        acc = 20'h04500 + 20'(total_len) + 20'(id) + 20'h04000 + 20'({ttl, 8'h11})
            + 20'(src[31:16]) + 20'(src[15:0]) + 20'(dst[31:16]) + 20'(dst[15:0]);
        acc = 20'(acc[15:0]) + 20'(acc[19:16]);
        acc = 20'(acc[15:0]) + 20'(acc[19:16]);
        return ~acc[15:0];
    endfunction

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPolyRefl) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_send_if.sv
// Byte-stream interface of the transmit framer.
//   data/data_vl : frame byte toward the PHY and its valid
//   pld_rd       : payload byte consumed from the FWFT buffer this cycle
//   pld_data     : head-of-buffer payload byte (valid while pld_rd is high)
interface eth_send_if;
    logic [7:0] data;
    logic       data_vl;
    logic       pld_rd;
    logic [7:0] pld_data;

    modport master (output data, output data_vl, output pld_rd, input pld_data);
    modport slave  (input data, input data_vl, input pld_rd, output pld_data);
endinterface

// File: rtl/eth_crc32_tx.sv
// Bytewise Ethernet FCS generator (reflected 0x04C11DB7, init all-ones, complemented out).
//   clk, rst : clock and synchronous active-high reset
//   i_init   : reload the all-ones seed
//   i_calc   : fold i_data into the running CRC this cycle
//   o_fcs    : complemented CRC, emitted low byte first
module eth_crc32_tx
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_calc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_fcs
);
    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (i_init) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (i_calc) begin
            crc_d = crc32_byte(crc_q, i_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 32'hFFFF_FFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_fcs = ~crc_q;
endmodule

// File: rtl/eth_send.sv
// Ethernet transmit framer: on an accepted start, emits preamble/SFD, MAC header, ARP body
// or IPv4+UDP headers, UDP payload, zero pad to 60 bytes and FCS, one byte per clock.
//   clk, rst          : clock, synchronous active-high reset
//   i_start/i_pkt_type: request and frame kind (ARP req/resp or UDP)
//   i_self_*/i_dst_*  : addresses; i_src_port/i_dst_port/i_pld_len: UDP fields
//   tx                : PHY byte stream and payload FWFT read port
//   o_busy/o_done/o_err: frame in flight (incl. IFG), last FCS byte, start rejected
module eth_send
    import eth_pkg::*;
#(
    parameter int unsigned P_IFG     = 12,
    parameter int unsigned P_TTL     = 64,
    parameter int unsigned P_MAX_PLD = 1472
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [1:0]  i_pkt_type,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic [47:0] i_dst_mac,
    input  logic [31:0] i_dst_ip,
    input  logic [15:0] i_src_port,
    input  logic [15:0] i_dst_port,
    input  logic [10:0] i_pld_len,
    eth_send_if.master  tx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    localparam logic [10:0] MaxPld  = 11'(P_MAX_PLD);
    localparam logic [10:0] IfgLast = 11'(P_IFG - 1);

    tx_state_e    state_q, state_d;
    pkt_type_e    type_q, type_d;
    logic [10:0]  cnt_q, cnt_d, len_q, len_d;
    logic [47:0]  smac_q, smac_d, dmac_q, dmac_d;
    logic [31:0]  sip_q, sip_d, dip_q, dip_d;
    logic [15:0]  sport_q, sport_d, dport_q, dport_d, id_q, id_d;
    logic [335:0] hdr_q, hdr_d;
    logic         err_q, err_d;

    logic         crc_init, crc_calc, pad_needed;
    logic [31:0]  fcs;
    logic [15:0]  tot_len, udp_len, csum;
    logic [10:0]  pld_bytes;

    assign tot_len    = 16'(len_q) + 16'd28;
    assign udp_len    = 16'(len_q) + 16'd8;
    assign csum       = ip_csum(tot_len, id_q, 8'(P_TTL), sip_q, dip_q);
    assign pld_bytes  = (type_q == PktUdp) ? len_q : 11'd0;
    assign pad_needed = (HdrLen + pld_bytes) < MinFrameLen;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 11'd1;
        type_d      = type_q;
        len_d       = len_q;
        smac_d      = smac_q;
        dmac_d      = dmac_q;
        sip_d       = sip_q;
        dip_d       = dip_q;
        sport_d     = sport_q;
        dport_d     = dport_q;
        id_d        = id_q;
        hdr_d       = hdr_q;
        err_d       = 1'b0;
        crc_init    = 1'b0;
        crc_calc    = 1'b0;
        tx.data     = 8'h00;
        tx.data_vl  = 1'b0;
        tx.pld_rd   = 1'b0;
        o_done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 11'd0;
                if (i_start && (i_pkt_type != 2'(PktNone))) begin
                    if (i_pld_len > MaxPld) begin
                        err_d = 1'b1;
                    end else begin
                        type_d  = pkt_type_e'(i_pkt_type);
                        len_d   = i_pld_len;
                        smac_d  = i_self_mac;
                        dmac_d  = i_dst_mac;
                        sip_d   = i_self_ip;
                        dip_d   = i_dst_ip;
                        sport_d = i_src_port;
                        dport_d = i_dst_port;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // Whole header is snapshotted here, checksum included, then shifted out
                if (type_q == PktUdp) begin
                    hdr_d = {dmac_q, smac_q, EtypeIpv4,
                             16'h4500, tot_len, id_q, 16'h4000, 8'(P_TTL), 8'h11, csum,
                             sip_q, dip_q, sport_q, dport_q, udp_len, 16'h0000};
                end else begin
                    hdr_d = {dmac_q, smac_q, EtypeArp, ArpFixedHdr,
                             14'd0, type_q, smac_q, sip_q,
                             (type_q == PktArpResp) ? dmac_q : 48'h0, dip_q};
                end
                crc_init = 1'b1;
                cnt_d    = 11'd0;
                state_d  = StPreamble;
            end
            StPreamble: begin
                tx.data_vl = 1'b1;
                tx.data    = (cnt_q == 11'd7) ? SfdByte : PreambleByte;
                if (cnt_q == 11'd7) begin
                    cnt_d   = 11'd0;
                    state_d = StHeader;
                end
            end
            StHeader: begin
                tx.data_vl = 1'b1;
                tx.data    = hdr_q[335:328];
                crc_calc   = 1'b1;
                hdr_d      = {hdr_q[327:0], 8'h00};
                if (cnt_q == HdrLen - 11'd1) begin
                    cnt_d = 11'd0;
                    if (pld_bytes != 11'd0) begin
                        state_d = StPayload;
                    end else if (pad_needed) begin
                        cnt_d   = HdrLen;
                        state_d = StPad;
                    end else begin
                        state_d = StFcs;
                    end
                end
            end
            StPayload: begin
                tx.data_vl = 1'b1;
                tx.pld_rd  = 1'b1;
                tx.data    = tx.pld_data;
                crc_calc   = 1'b1;
                if (cnt_q == len_q - 11'd1) begin
                    if (pad_needed) begin
                        // Pad counter tracks position after the SFD
                        cnt_d   = HdrLen + len_q;
                        state_d = StPad;
                    end else begin
                        cnt_d   = 11'd0;
                        state_d = StFcs;
                    end
                end
            end
            StPad: begin
                tx.data_vl = 1'b1;
                crc_calc   = 1'b1;
                if (cnt_q == MinFrameLen - 11'd1) begin
                    cnt_d   = 11'd0;
                    state_d = StFcs;
                end
            end
            StFcs: begin
                tx.data_vl = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    tx.data = fcs[7:0];
                    2'd1:    tx.data = fcs[15:8];
                    2'd2:    tx.data = fcs[23:16];
                    default: tx.data = fcs[31:24];
                endcase
                if (cnt_q == 11'd3) begin
                    o_done  = 1'b1;
                    cnt_d   = 11'd0;
                    state_d = StIfg;
                    if (type_q == PktUdp) begin
                        id_d = id_q + 16'd1;
                    end
                end
            end
            StIfg: begin
                if (cnt_q == IfgLast) begin
                    cnt_d   = 11'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            type_q  <= PktNone;
            len_q   <= '0;
            smac_q  <= '0;
            dmac_q  <= '0;
            sip_q   <= '0;
            dip_q   <= '0;
            sport_q <= '0;
            dport_q <= '0;
            id_q    <= '0;
            hdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            len_q   <= len_d;
            smac_q  <= smac_d;
            dmac_q  <= dmac_d;
            sip_q   <= sip_d;
            dip_q   <= dip_d;
            sport_q <= sport_d;
            dport_q <= dport_d;
            id_q    <= id_d;
            hdr_q   <= hdr_d;
            err_q   <= err_d;
        end
    end

    eth_crc32_tx u_crc (
        .clk    (clk),
        .rst    (rst),
        .i_init (crc_init),
        .i_calc (crc_calc),
        .i_data (tx.data),
        .o_fcs  (fcs)
    );

    assign o_busy = (state_q != StIdle);
    assign o_err  = err_q;
endmodule

// File: tb/tb_eth_send.sv
// Directed + randomized bench for eth_send; expected frames come from a byte-level model.
module tb_eth_send;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_pkt_type = '0;
    logic [47:0] i_self_mac = '0, i_dst_mac = '0;
    logic [31:0] i_self_ip = '0, i_dst_ip = '0;
    logic [15:0] i_src_port = '0, i_dst_port = '0;
    logic [10:0] i_pld_len = '0;
    logic        o_busy, o_done, o_err;

    eth_send_if tx ();

    eth_send #(.P_IFG(12), .P_TTL(64), .P_MAX_PLD(1472)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_pkt_type (i_pkt_type),
        .i_self_mac (i_self_mac),
        .i_self_ip  (i_self_ip),
        .i_dst_mac  (i_dst_mac),
        .i_dst_ip   (i_dst_ip),
        .i_src_port (i_src_port),
        .i_dst_port (i_dst_port),
        .i_pld_len  (i_pld_len),
        .tx         (tx),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Frame description used by both stimulus and model
    int          f_type, f_len;
    logic [47:0] f_smac, f_dmac;
    logic [31:0] f_sip, f_dip;
    logic [15:0] f_sport, f_dport, exp_id;
    logic [7:0]  pld[$], got[$], exp_q[$];
    logic [31:0] crc_tab[256];

    // Observations of the last run_frame
    int done_idx, rd_cnt, first_lat;
    bit gap, tmo, err_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields();
        i_pkt_type = 2'(f_type);
        i_self_mac = f_smac;
        i_dst_mac  = f_dmac;
        i_self_ip  = f_sip;
        i_dst_ip   = f_dip;
        i_src_port = f_sport;
        i_dst_port = f_dport;
        i_pld_len  = 11'(f_len);
    endtask

    task automatic scramble();
        i_pkt_type = 2'($urandom);
        i_self_mac = 48'({$urandom(), $urandom()});
        i_dst_mac  = 48'({$urandom(), $urandom()});
        i_self_ip  = $urandom;
        i_dst_ip   = $urandom;
        i_src_port = 16'($urandom);
        i_dst_port = 16'($urandom);
        i_pld_len  = 11'($urandom);
    endtask

    task automatic rand_fields(input int typ, input int len);
        f_type  = typ;
        f_len   = len;
        f_smac  = 48'({$urandom(), $urandom()});
        f_dmac  = 48'({$urandom(), $urandom()});
        f_sip   = $urandom;
        f_dip   = $urandom;
        f_sport = 16'($urandom);
        f_dport = 16'($urandom);
        pld.delete();
        for (int i = 0; i < len; i++) pld.push_back(8'($urandom));
    endtask

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endtask

    // Whole on-wire frame, preamble through FCS, from the field values.
    task automatic build_exp();
        int          h, s;
        logic [15:0] cs;
        logic [31:0] c;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push_be(f_dmac, 6);
        push_be(f_smac, 6);
        if (f_type == 3) begin
            push_be(16'h0800, 2);
            h = exp_q.size();
            push_be(16'h4500, 2);
            push_be(64'(f_len + 28), 2);
            push_be(exp_id, 2);
            push_be(16'h4000, 2);
            push_be({8'd64, 8'd17}, 2);
            push_be(16'h0000, 2);
            push_be(f_sip, 4);
            push_be(f_dip, 4);
            s = 0;
            for (int k = 0; k < 10; k++) s += int'({exp_q[h+2*k], exp_q[h+2*k+1]});
            while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
            cs = ~16'(s);
            exp_q[h+10] = cs[15:8];
            exp_q[h+11] = cs[7:0];
            push_be(f_sport, 2);
            push_be(f_dport, 2);
            push_be(64'(f_len + 8), 2);
            push_be(16'h0000, 2);
            foreach (pld[i]) exp_q.push_back(pld[i]);
        end else begin
            push_be(16'h0806, 2);
            push_be(48'h0001_0800_0604, 6);
            push_be(64'(f_type), 2);
            push_be(f_smac, 6);
            push_be(f_sip, 4);
            push_be((f_type == 2) ? f_dmac : 48'h0, 6);
            push_be(f_dip, 4);
        end
        while (exp_q.size() < 68) exp_q.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < exp_q.size(); i++) c = crc_tab[8'(c[7:0] ^ exp_q[i])] ^ (c >> 8);
        c = ~c;
        push_be({c[7:0], c[15:8], c[23:16], c[31:24]}, 4);
    endtask

    // Pulse start with the current fields, then capture every valid byte until o_done.
    task automatic run_frame(input bit hold);
        int pidx;
        bit started;
        got.delete();
        done_idx = -1; rd_cnt = 0; first_lat = -1; gap = 0; tmo = 1; err_seen = 0;
        pidx = 0; started = 0;
        drive_fields();
        i_start = 1'b1;
        tick();
        if (!hold) i_start = 1'b0;
        scramble();
        for (int cyc = 1; cyc < 4000; cyc++) begin
            tx.pld_data = (pidx < pld.size()) ? pld[pidx] : 8'($urandom);
            #1;
            if (o_err) err_seen = 1;
            if (tx.data_vl) begin
                if (!started) begin
                    started   = 1;
                    first_lat = cyc;
                end
                got.push_back(tx.data);
                if (tx.pld_rd) begin
                    rd_cnt++;
                    pidx++;
                end
                if (o_done) begin
                    done_idx = got.size() - 1;
                    tmo      = 0;
                end
            end else if (started) begin
                gap = 1;
            end
            if (!tmo || gap) break;
            tick();
        end
        i_start = 1'b0;
        tick();
    endtask

    task automatic check_frame(input string tag, input int exp_len);
        int mism, first;
        mism = 0; first = -1;
        check($sformatf("%s timeout", tag), 64'(tmo), 0);
        check($sformatf("%s len", tag), got.size(), exp_len);
        check($sformatf("%s model len", tag), got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("%s byte mismatches (first at %0d)", tag, first), mism, 0);
        check($sformatf("%s latency", tag), first_lat, 2);
        check($sformatf("%s done idx", tag), done_idx, exp_len - 1);
        check($sformatf("%s vl gap", tag), 64'(gap), 0);
        check($sformatf("%s err while busy", tag), 64'(err_seen), 0);
        if (f_type == 3) exp_id++;
    endtask

    // Count IFG cycles; optionally pulse a legal start at cycle pulse_at (must be ignored).
    task automatic wait_idle(input string tag, input int pulse_at);
        int cnt;
        bit vl_seen;
        cnt = 0; vl_seen = 0;
        while (o_busy && cnt < 100) begin
            i_start = (cnt == pulse_at);
            if (tx.data_vl) vl_seen = 1;
            cnt++;
            tick();
        end
        i_start = 1'b0;
        check($sformatf("%s ifg cycles", tag), cnt, 12);
        check($sformatf("%s vl in ifg", tag), 64'(vl_seen), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_id = 16'h0;
    endtask

    function automatic logic [15:0] got_word(input int i);
        return {got[i], got[i+1]};
    endfunction

    initial begin
        int s, n, quiet;
        bit found;
        logic [7:0] tha_or;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[i] = c;
        end
        tx.pld_data = 8'h00;

        // Reset state
        do_reset();
        check("reset data_vl", 64'(tx.data_vl), 0);
        check("reset busy", 64'(o_busy), 0);
        check("reset done", 64'(o_done), 0);
        check("reset err", 64'(o_err), 0);
        check("reset pld_rd", 64'(tx.pld_rd), 0);

        // ARP reply with the reference addresses
        f_type = 2; f_len = 0; pld.delete();
        f_smac = 48'h02_00_00_00_00_01; f_sip = 32'hC0A8_010A;
        f_dmac = 48'h00_11_22_33_44_55; f_dip = 32'hC0A8_0101;
        f_sport = 16'h1234; f_dport = 16'h5678;
        build_exp();
        run_frame(0);
        check_frame("arp_resp", 72);
        check("arp_resp ethertype", got_word(20), 16'h0806);
        check("arp_resp oper", got_word(28), 16'h0002);
        wait_idle("arp_resp", -1);

        // UDP with a 4-byte payload
        rand_fields(3, 4);
        pld = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_exp();
        run_frame(0);
        check_frame("udp4", 72);
        check("udp4 total_len", got_word(24), 16'h0020);
        check("udp4 udp_len", got_word(46), 16'h000C);
        check("udp4 pld_rd cycles", rd_cnt, 4);
        check("udp4 ip id", got_word(26), 16'h0000);
        s = 0;
        for (int k = 0; k < 10; k++) s += int'(got_word(22 + 2*k));
        while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
        check("udp4 ip csum verify", s, 'hFFFF);
        wait_idle("udp4", -1);

        // Maximum payload, then a start pulse inside the IFG that must be ignored
        rand_fields(3, 1472);
        build_exp();
        run_frame(0);
        check_frame("udp1472", 1526);
        check("udp1472 pld_rd cycles", rd_cnt, 1472);
        check("udp1472 ip id", got_word(26), 16'h0001);
        rand_fields(3, 10);
        drive_fields();
        wait_idle("udp1472", 5);
        quiet = 0;
        repeat (6) begin
            if (tx.data_vl || o_busy) quiet++;
            tick();
        end
        check("ifg start ignored", quiet, 0);

        // Back-to-back UDP after reset: id restarts at 0; start held high during frame 1
        do_reset();
        rand_fields(3, 0);
        build_exp();
        run_frame(1);
        check_frame("b2b_1", 72);
        check("b2b_1 ip id", got_word(26), 16'h0000);
        wait_idle("b2b_1", -1);
        rand_fields(3, int'($urandom_range(1, 40)));
        build_exp();
        run_frame(0);
        check_frame("b2b_2", exp_q.size());
        check("b2b_2 ip id", got_word(26), 16'h0001);
        wait_idle("b2b_2", -1);

        // Randomized mix of frame types and lengths
        for (int r = 0; r < 4; r++) begin
            rand_fields(int'($urandom_range(1, 3)), int'($urandom_range(0, 120)));
            build_exp();
            run_frame(0);
            check_frame($sformatf("rand%0d", r), exp_q.size());
            wait_idle($sformatf("rand%0d", r), -1);
        end

        // Oversize payload is rejected
        rand_fields(3, 1473);
        drive_fields();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("oversize err pulse", 64'(o_err), 1);
        check("oversize busy", 64'(o_busy), 0);
        tick();
        check("oversize err one cycle", 64'(o_err), 0);
        quiet = 0;
        repeat (20) begin
            if (tx.data_vl || o_busy || o_err) quiet++;
            tick();
        end
        check("oversize quiet", quiet, 0);

        // Type 0 does nothing
        rand_fields(0, 10);
        drive_fields();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        quiet = 0;
        repeat (20) begin
            if (tx.data_vl || o_busy || o_err) quiet++;
            tick();
        end
        check("type0 quiet", quiet, 0);

        // Reset in the middle of the header, then a clean ARP request
        rand_fields(2, 0);
        drive_fields();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0; found = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (tx.data_vl) begin
                if (n == 28) begin
                    found = 1;
                    break;
                end
                n++;
            end
            tick();
        end
        check("midreset reached hdr byte 20", 64'(found), 1);
        rst = 1'b1;
        tick();
        check("midreset data_vl", 64'(tx.data_vl), 0);
        check("midreset busy", 64'(o_busy), 0);
        rst = 1'b0;
        exp_id = 16'h0;
        tick();
        rand_fields(1, 0);
        build_exp();
        run_frame(0);
        check_frame("arp_req", 72);
        check("arp_req ethertype", got_word(20), 16'h0806);
        check("arp_req oper", got_word(28), 16'h0001);
        tha_or = 8'h00;
        for (int i = 40; i < 46 && i < got.size(); i++) tha_or |= got[i];
        check("arp_req tha zero", 64'(tha_or), 0);
        wait_idle("arp_req", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
